exe_stage: RTL



---
 rtl/exe_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, runs ALU / multiply / iterative divide,
// and issues the data-SRAM request for loads and stores.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [159:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic         out_es_valid,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic         es_valid_q;
  logic [159:0] es_bus_q;
  logic         es_ready_go;

  // Bundle fields
  logic [11:0] alu_op;
  logic        src1_is_pc, src2_is_imm, gr_we, res_from_mem;
  logic [31:0] pc, rj_value, imm, rkd_value;
  logic [4:0]  dest;
  logic [3:0]  mem_we;
  logic [6:0]  divmul_op;

  assign {alu_op, src1_is_pc, pc, rj_value, src2_is_imm, imm, rkd_value,
          gr_we, dest, res_from_mem, mem_we, divmul_op} = es_bus_q;

  logic mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu;
  assign {mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu} = divmul_op;

  logic is_div, is_mul, div_signed;
  assign is_div     = |divmul_op[3:0];
  assign is_mul     = mul_w | mulh_w | mulh_wu;
  assign div_signed = div_w | mod_w;

  logic [31:0] src1, src2;
  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : rkd_value;

  // Handshake
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign out_es_valid   = es_valid_q;

  // Stage valid and bundle register
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      if (es_allowin) es_valid_q <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) es_bus_q <= ds_to_es_bus;
    end
  end

  // ALU: one-hot op select, results OR-combined
  logic [31:0] alu_result;
  always_comb begin
    alu_result = '0;
    if (alu_op[0])  alu_result |= src1 + src2;
    if (alu_op[1])  alu_result |= src1 - src2;
    if (alu_op[2])  alu_result |= {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[3])  alu_result |= {31'b0, src1 < src2};
    if (alu_op[4])  alu_result |= src1 & src2;
    if (alu_op[5])  alu_result |= ~(src1 | src2);
    if (alu_op[6])  alu_result |= src1 | src2;
    if (alu_op[7])  alu_result |= src1 ^ src2;
    if (alu_op[8])  alu_result |= src1 << src2[4:0];
    if (alu_op[9])  alu_result |= src1 >> src2[4:0];
    if (alu_op[10]) alu_result |= $unsigned($signed(src1) >>> src2[4:0]);
    if (alu_op[11]) alu_result |= src2;
  end

  // Multiply: operands extended to 64 bits so the low 64 product bits are exact
  logic        mul_sext;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [31:0] mul_result;
  assign mul_sext   = !mulh_wu;
  assign mul_a      = {{32{mul_sext & src1[31]}}, src1};
  assign mul_b      = {{32{mul_sext & src2[31]}}, src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_result = mul_w ? mul_prod[31:0] : mul_prod[63:32];

  // Divider state
  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, dvz_q, dvz_d;

  logic        dividend_neg, divisor_neg;
  logic [31:0] abs_a, abs_b;
  assign dividend_neg = div_signed & src1[31];
  assign divisor_neg  = div_signed & src2[31];
  assign abs_a        = dividend_neg ? -src1 : src1;
  assign abs_b        = divisor_neg  ? -src2 : src2;

  // One restoring step: dividend bits shift out of quo_q as quotient bits shift in
  logic [32:0] rem_shift;
  logic        step_ge;
  assign rem_shift = {rem_q, quo_q[31]};
  assign step_ge   = rem_shift >= {1'b0, dvs_q};

  // Divider next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dvz_d   = dvz_q;
    unique case (state_q)
      StIdle: begin
        if (es_valid_q && is_div) begin
          state_d = StBusy;
          count_d = 5'd0;
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          q_neg_d = dividend_neg ^ divisor_neg;
          r_neg_d = dividend_neg;
          dvz_d   = (src2 == 32'd0);
        end
      end
      StBusy: begin
        rem_d   = step_ge ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
        quo_d   = {quo_q[30:0], step_ge};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        if (ms_allowin) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Divider registers; reset aborts any division in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dvz_q   <= dvz_d;
    end
  end

  assign es_ready_go = !is_div || (state_q == StDone);

  // Divide by zero forces an all-ones quotient; the remainder is already the dividend
  logic [31:0] quotient, remainder, div_result, result;
  assign quotient   = dvz_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
  assign remainder  = r_neg_q ? -rem_q : rem_q;
  assign div_result = (div_w | div_wu) ? quotient : remainder;
  assign result     = is_div ? div_result : (is_mul ? mul_result : alu_result);

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, result, pc};

  // Memory request
  assign data_sram_addr = alu_result;
  assign data_sram_en   = es_valid_q && (res_from_mem || (mem_we != 4'b0));
  assign data_sram_we   = (mem_we << alu_result[1:0]) & {4{es_valid_q}};

  // Replicate narrow store data across the word so byte strobes pick the right lane
  always_comb begin
    data_sram_wdata = rkd_value;
    case (mem_we)
      4'b0001: data_sram_wdata = {4{rkd_value[7:0]}};
      4'b0011: data_sram_wdata = {2{rkd_value[15:0]}};
      default: data_sram_wdata = rkd_value;
    endcase
  end

endmodule
